// File: rtl/multicore_load_ctrl.sv
// Load/run/readback sequencer for the N-core processor top: streams tagged words into
// per-core IRAMs or shared DRAM, runs the cores to done/timeout, then streams a DRAM window out.
`timescale 1ns/1ps

module multicore_load_ctrl #(
  parameter int N_CORES    = 8,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int BASE_ADDR  = 1,
  parameter int WR_CYCLES  = 4,
  parameter int RD_LAT     = 5,
  parameter int RUN_CYCLES = 120000,
  localparam int SEL_W     = $clog2(N_CORES + 1)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [SEL_W-1:0]   load_sel,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  input  logic               run_req,
  input  logic [ADDR_W-1:0]  rd_start,
  input  logic [ADDR_W-1:0]  rd_end,
  input  logic               proc_done,
  input  logic [DATA_W-1:0]  dram_in,
  output logic [ADDR_W-1:0]  addr_ext,
  output logic [DATA_W-1:0]  Data_in_ins,
  output logic [DATA_W-1:0]  Data_in_dram,
  output logic [N_CORES-1:0] iram_write_ext,
  output logic               dram_write_ext,
  output logic               read_en_ext,
  output logic               start,
  output logic               start_2,
  output logic               start_3,
  output logic               start_4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic               timeout,
  output logic               err_ovf
);

  localparam int CYC_W = $clog2(RUN_CYCLES + 1);
  localparam int WRC_W = $clog2(WR_CYCLES + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  // WRAP is the one-cycle gap after a write strobe; POST is the gap between start and start_4.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRAP,
    S_RUN,
    S_POST,
    S_READ
  } state_t;

  state_t state, state_next;

  logic [SEL_W-1:0]  sel_q;
  logic              last_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [WRC_W-1:0]  wr_cyc;
  logic [CYC_W-1:0]  run_cyc;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] rd_start_q;
  logic [ADDR_W-1:0] rd_end_q;
  logic              run_pend;

  logic run_go;
  logic accept;
  logic wr_end;
  logic run_exit;
  logic rd_nonempty;
  logic rd_sample;
  logic rd_hs;
  logic to_dram;

  // A pending or arriving run request outranks a new load word.
  // Gating with rst_n keeps load_ready low while reset is held.
  assign load_ready  = rst_n && (state == S_IDLE) && !run_req && !run_pend;
  assign busy        = (state != S_IDLE);
  assign run_go      = (state == S_IDLE) && (run_req || run_pend);
  assign accept      = load_valid && load_ready;
  assign to_dram     = (load_sel >= SEL_W'(N_CORES));
  assign wr_end      = (state == S_WRITE) && (wr_cyc == WRC_W'(WR_CYCLES - 1));
  assign run_exit    = (state == S_RUN) && (proc_done || (run_cyc >= CYC_W'(RUN_CYCLES - 1)));
  assign rd_nonempty = (rd_end_q > rd_start_q);
  assign rd_sample   = (state == S_READ) && read_en_ext && (lat_cnt == LAT_W'(RD_LAT - 1));
  assign rd_hs       = (state == S_READ) && out_valid && out_ready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so every path assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (run_go)      state_next = S_RUN;
        else if (accept) state_next = S_WRITE;
      end
      S_WRITE: if (wr_end) state_next = S_WRAP;
      S_WRAP:  state_next = S_IDLE;
      S_RUN:   if (run_exit) state_next = rd_nonempty ? S_POST : S_IDLE;
      S_POST:  state_next = S_READ;
      S_READ:  if (rd_hs && out_last) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sel_q          <= '0;
      last_q         <= 1'b0;
      wr_ptr         <= BASE;
      wr_cyc         <= '0;
      run_cyc        <= '0;
      lat_cnt        <= '0;
      rd_start_q     <= '0;
      rd_end_q       <= '0;
      run_pend       <= 1'b0;
      addr_ext       <= '0;
      Data_in_ins    <= '0;
      Data_in_dram   <= '0;
      iram_write_ext <= '0;
      dram_write_ext <= 1'b0;
      read_en_ext    <= 1'b0;
      start          <= 1'b0;
      start_2        <= 1'b0;
      start_3        <= 1'b0;
      start_4        <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_last       <= 1'b0;
      timeout        <= 1'b0;
      err_ovf        <= 1'b0;
    end else begin
      // Result window is captured whenever a run request is honoured (now or pending).
      if (run_req && (state inside {S_IDLE, S_WRITE, S_WRAP})) begin
        rd_start_q <= rd_start;
        rd_end_q   <= rd_end;
      end
      if (run_req && (state inside {S_WRITE, S_WRAP})) run_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (run_go) begin
            run_pend <= 1'b0;
            timeout  <= 1'b0;
            start_2  <= 1'b0;
            start_3  <= 1'b0;
            start    <= 1'b1;
            run_cyc  <= '0;
          end else if (accept) begin
            sel_q    <= load_sel;
            last_q   <= load_last;
            wr_cyc   <= '0;
            addr_ext <= (load_sel != sel_q) ? BASE : wr_ptr;
            if (to_dram) begin
              dram_write_ext <= 1'b1;
              Data_in_dram   <= load_data;
              start_2        <= 1'b0;
              start_3        <= 1'b1;
            end else begin
              iram_write_ext <= N_CORES'(1) << load_sel;
              Data_in_ins    <= load_data;
              start_2        <= 1'b1;
              start_3        <= 1'b0;
            end
          end
        end

        S_WRITE: begin
          if (wr_end) begin
            iram_write_ext <= '0;
            dram_write_ext <= 1'b0;
          end else begin
            wr_cyc <= wr_cyc + 1'b1;
          end
        end

        S_WRAP: begin
          if (last_q) begin
            wr_ptr <= BASE;
          end else if (addr_ext == '1) begin
            err_ovf <= 1'b1;
            wr_ptr  <= BASE;
          end else begin
            wr_ptr <= addr_ext + 1'b1;
          end
        end

        S_RUN: begin
          if (run_exit) begin
            start <= 1'b0;
            if (!proc_done) timeout <= 1'b1;
          end else if (run_cyc != '1) begin
            run_cyc <= run_cyc + 1'b1;
          end
        end

        S_POST: begin
          addr_ext    <= rd_start_q;
          start_4     <= 1'b1;
          read_en_ext <= 1'b1;
          lat_cnt     <= '0;
        end

        S_READ: begin
          if (rd_sample) begin
            out_data    <= dram_in;
            read_en_ext <= 1'b0;
            out_valid   <= 1'b1;
            out_last    <= (addr_ext == rd_end_q - 1'b1);
          end else if (read_en_ext) begin
            lat_cnt <= lat_cnt + 1'b1;
          end
          if (rd_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              start_4 <= 1'b0;
            end else begin
              addr_ext    <= addr_ext + 1'b1;
              read_en_ext <= 1'b1;
              lat_cnt     <= '0;
            end
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_load_ctrl.sv
// Directed bench for multicore_load_ctrl: table-driven load vectors plus hand-written
// run/readback, stall, timeout, pending-run, overflow and mid-write reset sequences.
`timescale 1ns/1ps

module tb_multicore_load_ctrl;

  localparam int N_CORES    = 8;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 16;
  localparam int WR_CYCLES  = 4;
  localparam int RD_LAT     = 5;
  localparam int RUN_CYCLES = 200;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [3:0]        load_sel = '0;
  logic [15:0]       load_data = '0;
  logic              load_last = 1'b0;
  logic              run_req = 1'b0;
  logic [8:0]        rd_start = '0;
  logic [8:0]        rd_end = '0;
  logic              proc_done = 1'b0;
  logic [15:0]       dram_in = '0;
  logic [8:0]        addr_ext;
  logic [15:0]       Data_in_ins;
  logic [15:0]       Data_in_dram;
  logic [7:0]        iram_write_ext;
  logic              dram_write_ext;
  logic              read_en_ext;
  logic              start, start_2, start_3, start_4;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_data;
  logic              out_last;
  logic              busy;
  logic              timeout;
  logic              err_ovf;

  int n_chk = 0;
  int n_err = 0;
  int excl_bad = 0;
  int re_cnt = 0;

  multicore_load_ctrl #(
    .N_CORES(N_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(1),
    .WR_CYCLES(WR_CYCLES), .RD_LAT(RD_LAT), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
    .load_data(load_data), .load_last(load_last),
    .run_req(run_req), .rd_start(rd_start), .rd_end(rd_end), .proc_done(proc_done),
    .dram_in(dram_in), .addr_ext(addr_ext), .Data_in_ins(Data_in_ins),
    .Data_in_dram(Data_in_dram), .iram_write_ext(iram_write_ext),
    .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext),
    .start(start), .start_2(start_2), .start_3(start_3), .start_4(start_4),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .timeout(timeout), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] dram_word(input logic [8:0] a);
    return {7'h50, a};
  endfunction

  // DRAM model: data is only correct once read_en_ext has been high for RD_LAT cycles.
  always @(negedge clock) begin
    if (read_en_ext) re_cnt = re_cnt + 1;
    else             re_cnt = 0;
    dram_in = (re_cnt == RD_LAT) ? dram_word(addr_ext) : 16'hBAD0;
  end

  always @(negedge clock) begin
    if (rst_n) begin
      if ($countones({start, start_2, start_3, start_4}) > 1 ||
          $countones({dram_write_ext, iram_write_ext}) > 1 ||
          ((start || start_4 || read_en_ext) && (dram_write_ext || |iram_write_ext)))
        excl_bad = excl_bad + 1;
    end
  end

  function automatic logic [79:0] all_outs();
    return 80'({load_ready, addr_ext, Data_in_ins, Data_in_dram, iram_write_ext,
                dram_write_ext, read_en_ext, start, start_2, start_3, start_4,
                out_valid, out_data, out_last, busy, timeout, err_ovf});
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge after the controller is idle again.
  task automatic write_word(input logic [3:0] sel, input logic [15:0] data, input logic last,
                            output logic [8:0] a_seen, output logic [8:0] stb_seen,
                            output logic [15:0] d_seen, output int hi, output int bz,
                            output logic stable, output logic s2, output logic s3);
    int n;
    load_valid = 1'b1; load_sel = sel; load_data = data; load_last = last;
    n = 0;
    while (!load_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("load_ready_wait", load_ready, 1);
    @(posedge clock);
    #1 load_valid = 1'b0; load_last = 1'b0;
    hi = 0; bz = 0; stable = 1'b1; a_seen = '0; stb_seen = '0; d_seen = '0; s2 = 1'b0; s3 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!busy) break;
      bz++;
      if (dram_write_ext || |iram_write_ext) begin
        if (hi == 0) begin
          a_seen = addr_ext; stb_seen = {dram_write_ext, iram_write_ext};
          d_seen = dram_write_ext ? Data_in_dram : Data_in_ins;
          s2 = start_2; s3 = start_3;
        end else if (a_seen !== addr_ext || stb_seen !== {dram_write_ext, iram_write_ext} ||
                     d_seen !== (dram_write_ext ? Data_in_dram : Data_in_ins)) begin
          stable = 1'b0;
        end
        hi++;
      end
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge after the controller is idle again.
  task automatic run_and_read(input logic [8:0] rs, input logic [8:0] re, input int done_at,
                              input int stall_idx, input int exp_sc, input logic exp_to);
    int sc, words, nexp;
    logic stall_ok;
    logic [15:0] held;
    logic [8:0] exp_a;
    nexp = (re > rs) ? int'(re - rs) : 0;
    rd_start = rs; rd_end = re; run_req = 1'b1;
    @(posedge clock);
    #1 run_req = 1'b0;
    sc = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock);
      if (!start) break;
      sc++;
      if (sc == 1) begin
        check("run_clears_timeout", timeout, 0);
        check("run_drops_load_modes", {start_2, start_3}, 0);
      end
      if (done_at != 0 && sc == done_at) proc_done = 1'b1;
    end
    proc_done = 1'b0;
    check("start_cycles", sc, exp_sc);
    check("timeout_flag", timeout, exp_to);
    words = 0; stall_ok = 1'b1;
    for (int n = 0; n < 500; n++) begin
      if (!busy) break;
      if (out_valid) begin
        exp_a = rs + 9'(words);
        check("rd_addr", addr_ext, exp_a);
        check("rd_data", out_data, dram_word(exp_a));
        check("rd_last", out_last, words == nexp - 1);
        check("rd_en_and_mode", {read_en_ext, start_4}, 2'b01);
        if (words == stall_idx) begin
          out_ready = 1'b0; held = out_data;
          repeat (10) begin
            @(negedge clock);
            if (!out_valid || out_data !== held || read_en_ext || addr_ext !== exp_a) stall_ok = 1'b0;
          end
          out_ready = 1'b1;
        end
        words++;
      end
      @(negedge clock);
    end
    check("rd_words", words, nexp);
    check("idle_after_read", {busy, start_4, out_valid}, 0);
    check("timeout_sticky", timeout, exp_to);
    if (stall_idx >= 0) check("stall_hold", stall_ok, 1);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] data;
    logic        last;
    logic [8:0]  exp_addr;
    logic [8:0]  exp_stb;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] a_seen, stb_seen;
    logic [15:0] d_seen;
    int hi, bz, sc;
    logic stable, s2, s3, seen, ov;

    vecs[0] = '{4'd2, 16'd10,    1'b0, 9'd1, 9'b0_0000_0100};
    vecs[1] = '{4'd2, 16'd20,    1'b0, 9'd2, 9'b0_0000_0100};
    vecs[2] = '{4'd2, 16'd30,    1'b1, 9'd3, 9'b0_0000_0100};
    vecs[3] = '{4'd2, 16'h0040,  1'b1, 9'd1, 9'b0_0000_0100};
    vecs[4] = '{4'd3, 16'h0333,  1'b0, 9'd1, 9'b0_0000_1000};
    vecs[5] = '{4'd3, 16'h0334,  1'b0, 9'd2, 9'b0_0000_1000};
    vecs[6] = '{4'd4, 16'h0444,  1'b1, 9'd1, 9'b0_0001_0000};
    for (int k = 0; k < 8; k++) begin
      vecs[7 + 2*k]     = '{4'(k), 16'h1000 + 16'(2*k), 1'b0, 9'd1, 9'd1 << k};
      vecs[7 + 2*k + 1] = '{4'(k), 16'h1001 + 16'(2*k), 1'b1, 9'd2, 9'd1 << k};
    end
    vecs[23] = '{4'd8, 16'hD001, 1'b0, 9'd1, 9'h100};
    vecs[24] = '{4'd8, 16'hD002, 1'b0, 9'd2, 9'h100};
    vecs[25] = '{4'd8, 16'hD003, 1'b0, 9'd3, 9'h100};
    vecs[26] = '{4'd8, 16'hD004, 1'b1, 9'd4, 9'h100};

    #23;
    check("reset_outputs", all_outs(), 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("ready_after_reset", {load_ready, busy, start, start_2, start_3, start_4}, 6'b100000);

    for (int i = 0; i < NV; i++) begin
      write_word(vecs[i].sel, vecs[i].data, vecs[i].last, a_seen, stb_seen, d_seen, hi, bz, stable, s2, s3);
      check("wr_addr", a_seen, vecs[i].exp_addr);
      check("wr_strobe", stb_seen, vecs[i].exp_stb);
      check("wr_data", d_seen, vecs[i].data);
      check("wr_strobe_cycles", hi, WR_CYCLES);
      check("wr_busy_cycles", bz, WR_CYCLES + 1);
      check("wr_stable", stable, 1);
      check("wr_mode_flags", {s2, s3}, (vecs[i].sel < 8) ? 2'b10 : 2'b01);
    end

    run_and_read(9'd100, 9'd103, 50, -1, 50, 1'b0);
    run_and_read(9'd100, 9'd103, 0, 1, RUN_CYCLES, 1'b1);
    run_and_read(9'd5, 9'd5, 3, -1, 3, 1'b0);

    // run_req during WRITE is held until the write finishes; run_req during RUN is ignored.
    load_valid = 1'b1; load_sel = 4'd5; load_data = 16'h5555; load_last = 1'b1;
    @(posedge clock);
    #1 load_valid = 1'b0; load_last = 1'b0;
    @(negedge clock);
    hi = (|iram_write_ext) ? 1 : 0;
    rd_start = 9'd7; rd_end = 9'd7; run_req = 1'b1;
    @(posedge clock);
    #1 run_req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (|iram_write_ext) hi++;
      if (start) begin
        seen = 1'b1;
        break;
      end
    end
    check("pend_run_taken", seen, 1);
    check("pend_write_completes", hi, WR_CYCLES);
    rd_start = 9'd20; rd_end = 9'd22; run_req = 1'b1;
    @(posedge clock);
    #1 run_req = 1'b0;
    @(negedge clock);
    proc_done = 1'b1;
    @(posedge clock);
    #1 proc_done = 1'b0;
    ov = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (out_valid) ov = 1'b1;
      if (!busy) break;
    end
    check("pend_empty_no_valid", ov, 0);
    repeat (5) @(negedge clock);
    check("run_req_ignored_in_run", {start, start_4, busy}, 0);

    // Address overflow: 511 words to core 0 without load_last.
    for (int i = 1; i <= 511; i++) begin
      write_word(4'd0, 16'(i), 1'b0, a_seen, stb_seen, d_seen, hi, bz, stable, s2, s3);
      if (i == 1)   check("ovf_first_addr", a_seen, 9'd1);
      if (i == 510) check("ovf_not_yet", err_ovf, 0);
      if (i == 511) begin
        check("ovf_top_addr", a_seen, 9'd511);
        check("ovf_flag", err_ovf, 1);
      end
    end
    write_word(4'd0, 16'hFFFF, 1'b1, a_seen, stb_seen, d_seen, hi, bz, stable, s2, s3);
    check("ovf_wrap_addr", a_seen, 9'd1);
    check("ovf_sticky", err_ovf, 1);

    // Reset pulse in the middle of a write.
    load_valid = 1'b1; load_sel = 4'd1; load_data = 16'h1234; load_last = 1'b0;
    @(posedge clock);
    #1 load_valid = 1'b0;
    @(negedge clock);
    check("rst_pre_strobe", iram_write_ext, 8'b0000_0010);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_write", all_outs(), 0);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    write_word(4'd1, 16'h4321, 1'b1, a_seen, stb_seen, d_seen, hi, bz, stable, s2, s3);
    check("post_reset_addr", a_seen, 9'd1);
    check("post_reset_strobe", stb_seen, 9'b0_0000_0010);

    check("exclusivity", excl_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
